// File: rtl/vram_pkg.sv
// vram_pkg: framebuffer geometry, pixel/command types and fill FSM states shared by the VRAM blocks.
package vram_pkg;
  localparam logic [8:0] FB_WIDTH_DEF = 9'd160;
  localparam logic [8:0] FB_HEIGHT_DEF = 9'd120;
  localparam logic [15:0] FB_BASE_DEF = 16'h0000;
  typedef struct packed {
    logic [3:0] spare;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] w;
    logic [7:0] h;
    pixel_t color;
  } fill_cmd_t;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_SETUP = 2'd1;
  localparam state_t S_WRITE = 2'd2;
  localparam state_t S_DONE = 2'd3;
endpackage

// File: rtl/vram_fill.sv
// vram_fill: clipped rectangle fill, one pixel write per cycle into VRAM with write-port backpressure.
module vram_fill
  import vram_pkg::*;
#(
  parameter logic [8:0] FB_WIDTH = FB_WIDTH_DEF,
  parameter logic [8:0] FB_HEIGHT = FB_HEIGHT_DEF,
  parameter logic [15:0] FB_BASE = FB_BASE_DEF
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [7:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [15:0] cmd_color,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_ready,
  output logic        busy,
  output logic        done
);
  state_t state;
  fill_cmd_t cmd;
  logic [7:0] col, row, nxt_col;
  logic [15:0] row_base, nxt_base, setup_base;
  logic [8:0] x_end, y_end;
  logic empty, last_col, last_row;

  function automatic logic [8:0] clip(input logic [7:0] a, input logic [7:0] b, input logic [8:0] lim);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s > lim ? lim : s;
  endfunction

  assign x_end = clip(cmd.x, cmd.w, FB_WIDTH);
  assign y_end = clip(cmd.y, cmd.h, FB_HEIGHT);
  assign empty = cmd.w == 8'd0 || cmd.h == 8'd0 || {1'b0, cmd.x} >= FB_WIDTH || {1'b0, cmd.y} >= FB_HEIGHT;
  assign last_col = {1'b0, col} + 9'd1 == x_end;
  assign last_row = {1'b0, row} + 9'd1 == y_end;
  assign nxt_col = last_col ? cmd.x : col + 8'd1;
  assign nxt_base = last_col ? row_base + 16'(FB_WIDTH) : row_base;
  assign setup_base = FB_BASE + 16'(cmd.y) * 16'(FB_WIDTH);
  assign cmd_ready = clear && state == S_IDLE;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
      cmd <= '0;
      col <= '0;
      row <= '0;
      row_base <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          cmd <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
          busy <= 1'b1;
          state <= S_SETUP;
        end
        S_SETUP: if (empty) begin
          done <= 1'b1;
          state <= S_DONE;
        end else begin
          col <= cmd.x;
          row <= cmd.y;
          row_base <= setup_base;
          wr_en <= 1'b1;
          wr_addr <= setup_base + 16'(cmd.x);
          wr_data <= cmd.color;
          state <= S_WRITE;
        end
        // outputs advance only when the port takes the current write, so stalls hold them
        S_WRITE: if (wr_ready) begin
          if (last_col && last_row) begin
            wr_en <= 1'b0;
            done <= 1'b1;
            state <= S_DONE;
          end else begin
            col <= nxt_col;
            row <= last_col ? row + 8'd1 : row;
            row_base <= nxt_base;
            wr_addr <= nxt_base + 16'(nxt_col);
          end
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vram_fill.sv
// tb_vram_fill: table-driven, hand-written and randomized fills checked against a pixel-list reference model.
module tb_vram_fill;
  logic clock = 1'b0, clear = 1'b0, cmd_valid = 1'b0, cmd_ready, wr_en, wr_ready = 1'b1, busy, done;
  logic [7:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [15:0] cmd_color = '0, wr_addr, wr_data;
  int errors = 0, checks = 0;
  logic [15:0] got_a[$], got_d[$], exp_a[$], exp_d[$];

  typedef struct {
    logic [7:0] x, y, w, h;
    logic [15:0] c;
    int n, fa, la;
  } vec_t;
  vec_t v[9];

  vram_fill dut (
    .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: every on-screen pixel of the rectangle, row-major.
  task automatic model(input int x, input int y, input int w, input int h, input logic [15:0] c);
    exp_a.delete();
    exp_d.delete();
    for (int r = y; r < y + h && r < 120; r++)
      for (int k = x; k < x + w && k < 160; k++) begin
        exp_a.push_back(16'(r * 160 + k));
        exp_d.push_back(c);
      end
  endtask

  // mode 0: wr_ready=1, 1: random wr_ready, 2: pattern 1,0,0,1,0,1 over wr_en cycles
  task automatic run_cmd(input logic [7:0] x, y, w, h, input logic [15:0] c, input int mode);
    int first = -1, donec = -1, busyn = 0, pi = 0, n;
    bit stalled = 0;
    logic [15:0] pa = '0, pd = '0;
    logic [5:0] pat = 6'b101001;
    model(x, y, w, h, c);
    n = exp_a.size();
    got_a.delete();
    got_d.delete();
    @(negedge clock);
    chk("ready_before_cmd", cmd_ready, 1);
    {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color} = {x, y, w, h, c};
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color} = 48'($urandom()) ^ {$urandom(), 16'h0};
    for (int cyc = 1; cyc < 8000; cyc++) begin
      wr_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom()) : (wr_en ? (pi < 6 ? pat[pi] : 1'b1) : 1'b1);
      if (mode == 2 && wr_en) pi++;
      if (stalled) begin
        chk("stall_wr_en", wr_en, 1);
        chk("stall_addr", wr_addr, pa);
        chk("stall_data", wr_data, pd);
      end
      if (wr_en && first < 0) first = cyc;
      if (wr_en && wr_ready) begin
        got_a.push_back(wr_addr);
        got_d.push_back(wr_data);
      end
      stalled = wr_en && !wr_ready;
      {pa, pd} = {wr_addr, wr_data};
      if (busy) busyn++;
      if (done) begin
        donec = cyc;
        break;
      end
      @(negedge clock);
    end
    wr_ready = 1'b1;
    chk("done_seen", donec > 0, 1);
    chk("write_count", got_a.size(), n);
    for (int i = 0; i < n && i < got_a.size(); i++) begin
      chk("write_addr", got_a[i], exp_a[i]);
      chk("write_data", got_d[i], exp_d[i]);
    end
    if (mode == 0) begin
      chk("first_write_cycle", first, n > 0 ? 2 : -1);
      chk("done_cycle", donec, n + 2);
      chk("busy_cycles", busyn, n + 2);
    end
    @(negedge clock);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("ready_after_done", cmd_ready, 1);
    chk("wr_en_after_done", wr_en, 0);
  endtask

  initial begin
    int nw;
    v[0] = '{2, 3, 4, 2, 16'h0F00, 8, 482, 645};
    v[1] = '{158, 119, 10, 10, 16'hA5A5, 2, 19198, 19199};
    v[2] = '{5, 5, 0, 3, 16'h1111, 0, 0, 0};
    v[3] = '{200, 5, 3, 3, 16'h2222, 0, 0, 0};
    v[4] = '{0, 120, 1, 1, 16'h3333, 0, 0, 0};
    v[5] = '{0, 0, 1, 1, 16'h1234, 1, 0, 0};
    v[6] = '{0, 0, 160, 1, 16'hF0F0, 160, 0, 159};
    v[7] = '{150, 0, 255, 2, 16'h0ABC, 20, 150, 319};
    v[8] = '{0, 118, 2, 255, 16'hFFFF, 4, 18880, 19041};
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run_cmd(v[i].x, v[i].y, v[i].w, v[i].h, v[i].c, 0);
      chk("table_n", got_a.size(), v[i].n);
      if (v[i].n > 0 && got_a.size() > 0) begin
        chk("table_first_addr", got_a[0], v[i].fa);
        chk("table_last_addr", got_a[got_a.size() - 1], v[i].la);
      end
    end
    run_cmd(0, 0, 3, 1, 16'h0777, 2);
    for (int i = 0; i < 30; i++)
      run_cmd(8'($urandom_range(0, 170)), 8'($urandom_range(0, 125)), 8'($urandom_range(0, 20)),
              8'($urandom_range(0, 12)), 16'($urandom()), 1);
    // reset in the middle of a 10x10 fill, after five completed writes
    @(negedge clock);
    {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color} = {8'd0, 8'd0, 8'd10, 8'd10, 16'h0CCC};
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    nw = 0;
    for (int cyc = 0; cyc < 20 && nw < 5; cyc++) begin
      if (wr_en) nw++;
      @(negedge clock);
    end
    chk("mid_writes_before_reset", nw, 5);
    chk("sixth_write_pending", wr_en, 1);
    clear = 1'b0;
    #1;
    chk("async_rst_wr_en", wr_en, 0);
    chk("async_rst_addr", wr_addr, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", cmd_ready, 0);
    repeat (3) begin
      @(negedge clock);
      chk("rst_hold_wr_en", wr_en, 0);
    end
    clear = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_release_ready", cmd_ready, 1);
    chk("rst_release_wr_en", wr_en, 0);
    run_cmd(7, 7, 1, 1, 16'h0BEE, 0);
    chk("post_rst_single_addr", got_a.size() == 1 ? int'(got_a[0]) : -1, 7 * 160 + 7);
    // back-to-back with cmd_valid held; fields change to the second command after acceptance
    @(negedge clock);
    got_a.delete();
    got_d.delete();
    {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color} = {8'd1, 8'd1, 8'd2, 8'd1, 16'h0AAA};
    cmd_valid = 1'b1;
    @(negedge clock);
    {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color} = {8'd10, 8'd2, 8'd1, 8'd1, 16'h0BBB};
    nw = -1;
    for (int cyc = 1; cyc < 12; cyc++) begin
      if (wr_en) begin
        got_a.push_back(wr_addr);
        got_d.push_back(wr_data);
      end
      if (cmd_ready && nw < 0) nw = cyc;
      @(negedge clock);
      if (nw > 0) cmd_valid = 1'b0;
    end
    chk("b2b_ready_return", nw, 5);
    chk("b2b_count", got_a.size(), 3);
    if (got_a.size() == 3) begin
      chk("b2b_a0", got_a[0], 161);
      chk("b2b_a1", got_a[1], 162);
      chk("b2b_a2", got_a[2], 330);
      chk("b2b_d0", got_d[0], 16'h0AAA);
      chk("b2b_d1", got_d[1], 16'h0AAA);
      chk("b2b_d2", got_d[2], 16'h0BBB);
    end
    chk("b2b_idle", cmd_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vram_fill.md
# vram_fill

Rectangle-fill engine that writes pixel words into video RAM, the write side of the framebuffer that the VGA scan-out reads. It accepts one fill command at a time over a valid/ready handshake and emits one 16-bit pixel write per cycle on a RAM write port, clipped to the framebuffer. It sits between the CPU command path and the VRAM write port, in the CPU clock domain.

## Interface
- FB_WIDTH, 160: framebuffer width in pixels (words per row)
- FB_HEIGHT, 120: framebuffer height in rows
- FB_BASE, 16'h0000: VRAM word address of pixel (0,0)
- clock  input  1  system clock, all logic on rising edge
- clear  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  engine can accept a command
- cmd_x  input  8  left column
- cmd_y  input  8  top row
- cmd_w  input  8  width in pixels
- cmd_h  input  8  height in rows
- cmd_color  input  16  pixel word; bits 11:0 are RGB 4:4:4, bits 15:12 are written unchanged
- wr_en  output  1  write strobe
- wr_addr  output  16  VRAM word address
- wr_data  output  16  pixel word
- wr_ready  input  1  port accepts the write this cycle
- busy  output  1  command in progress
- done  output  1  one-cycle pulse when a command completes

## Operation
- States: IDLE, SETUP, WRITE, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch all cmd_* fields and go to SETUP. Fields are ignored at all other times.
- SETUP: clip the rectangle.
  - x_end = min(cmd_x+cmd_w, FB_WIDTH); y_end = min(cmd_y+cmd_h, FB_HEIGHT). Sums are 9-bit, with no wrap.
  - If cmd_w==0, cmd_h==0, cmd_x>=FB_WIDTH or cmd_y>=FB_HEIGHT, go to DONE with zero writes.
  - Otherwise set row_base = FB_BASE + cmd_y*FB_WIDTH (constant multiply, 16-bit, modulo 2^16), set the column counter to cmd_x, and go to WRITE.
- WRITE: wr_en=1, wr_addr=row_base+col, wr_data=latched color.
  - A write completes on a cycle with wr_en&wr_ready.
  - On completion, col increments. If col+1==x_end: col reloads cmd_x, row_base += FB_WIDTH, row increments.
  - If the completing write is at (x_end-1, y_end-1), go to DONE.
  - Rows are written top to bottom, columns left to right.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in SETUP, WRITE and DONE; busy=0 in IDLE.
- Backpressure: while wr_en=1 and wr_ready=0, wr_en, wr_addr and wr_data hold stable. No write is dropped or duplicated.
- Reset (clear=0), at any time including mid-fill: state goes to IDLE and no further writes are issued. Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, done=0, busy=0
  - cmd_ready=0 while clear=0, then 1 in IDLE after release.
- No read-back: VRAM contents outside the clipped rectangle are never touched.

## Timing
- Command accepted at edge N. SETUP in cycle N+1. First wr_en=1 in cycle N+2.
- With wr_ready held at 1, a clipped W×H fill uses W·H consecutive write cycles. done is asserted in the cycle after the last write, and cmd_ready returns the cycle after that.
- Total occupancy is W·H+3 cycles from acceptance to the next possible acceptance. An empty fill takes 3 cycles: SETUP, DONE, then IDLE.
- Throughput is one pixel per cycle, with no gap at row boundaries.
- wr_en, wr_addr, wr_data, done and busy are registered outputs. cmd_ready is decoded from state.

## Structure
- Shared package vram_pkg: FB_WIDTH/FB_HEIGHT defaults, pixel word typedef (rgb444 plus 4 spare bits), fill command struct (x, y, w, h, color), state enum. The VGA block uses the same geometry constants.
- Single module with no sub-module. The clip/limit computation is a local function.

## Test plan
- Fill x=2,y=3,w=4,h=2,color=16'h0F00, FB_WIDTH=160, wr_ready=1 → 8 writes at addresses 482..485 then 642..645, all data 16'h0F00; first write 2 cycles after acceptance; done 1 cycle after the last write.
- Fill x=158,y=119,w=10,h=10 → clipped to 2 writes only, at addresses 19198 and 19199.
- Fill w=0, and separately x=200 → zero wr_en cycles; done pulses at acceptance+2; busy high for exactly 2 cycles.
- Fill 3×1 with wr_ready toggling 1,0,0,1,0,1 → wr_addr and wr_data stable during stalls; exactly 3 accepted writes in order; no duplicates.
- Reset asserted after the 5th write of a 10×10 fill → wr_en=0 immediately and stays 0; after release cmd_ready=1, and a new 1×1 fill writes exactly one pixel.
- Back-to-back commands with cmd_valid held high → second command accepted the cycle cmd_ready returns; no fields leak from the first command.
